sif_xa_initiator: RTL and testbench
===================================

# sif_xa_initiator

Synthesizable XA-bus initiator for the SIF design: accepts WRITE/READ commands on a valid/ready command port and drives the XA strobe bus (`xa_wr_s`, `xa_rd_s`, address, write data) toward an XA responder. It waits for the responder's acknowledge, captures read data, and returns one response per command with an error flag for illegal operations or timeouts. It replaces the behavioural bench driver wherever RTL must master the XA bus, for example in loopback and self-test builds.

## Interface
- `ADDR_W`, 8: XA address width.
- `DATA_W`, 16: XA data width.
- `TIMEOUT`, 15: maximum strobe cycles without `xa_ack` before aborting; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command can be accepted.
- `cmd_op` in 2: {wr, rd}; 2'b10 = WRITE, 2'b01 = READ, 2'b11 and 2'b00 are illegal.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data.
- `xa_wr_s` out 1: write strobe.
- `xa_rd_s` out 1: read strobe.
- `xa_addr` out ADDR_W: bus address.
- `xa_data_wr` out DATA_W: bus write data.
- `xa_ack` in 1: responder completion.
- `xa_data_rd` in DATA_W: read data, valid in the `xa_ack` cycle.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out DATA_W: read data; 0 for writes and for errors.
- `rsp_err` out 1: illegal op or timeout.
- `rsp_checksum` out DATA_W: present only with the macro (see Configuration).

## Operation
- State machine with states IDLE, WRITE, READ and RESP. Reset state is IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept, register addr/wdata onto `xa_addr`/`xa_data_wr`.
  - Op 10 → WRITE, op 01 → READ.
  - Illegal op → RESP with `rsp_err` = 1 and no strobe issued.
- **WRITE / READ**
  - Corresponding strobe held high; the other strobe is 0. Both strobes are never high together.
  - The wait counter increments each strobe cycle.
  - `xa_ack` = 1 → drop strobe, latch `rsp_data` (`xa_data_rd` for READ, 0 for WRITE), `rsp_err` = 0, go to RESP.
  - Counter reaches TIMEOUT without ack → drop strobe, `rsp_data` = 0, `rsp_err` = 1, go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data` and `rsp_err` held stable.
  - On `rsp_ready` → IDLE.
- `xa_ack` outside WRITE/READ is ignored.
- `cmd_ready` = 0 in every state except IDLE.
- `xa_addr`/`xa_data_wr` hold their last value between transactions.
- Counter is 8 bits wide, cleared on entry to WRITE/READ, and never wraps.

## Timing
- Reset values: `cmd_ready` = 0 during reset and 1 in the first cycle after. All other outputs are 0; counter is 0.
- Command accepted at edge N.
- Strobe high from cycle N+1.
- Ack sampled at edge M ≥ N+1 → strobe low and `rsp_valid` high from cycle M+1.
- Minimum accept-to-response latency is 2 cycles.
- Ack in the first strobe cycle is legal.
- Timeout: strobe is high for exactly TIMEOUT cycles; `rsp_valid` rises in the next cycle.
- Illegal op accepted at N → `rsp_valid` at N+1.
- Back-to-back: response handshake at edge R → `cmd_ready` = 1 in cycle R+1 → next strobe no earlier than R+2.
- `rsp_ready` held high: RESP lasts exactly one cycle.
- Reset asserted mid-transaction: at the next edge, strobes drop, the pending command and response are discarded, and the block enters IDLE.

## Configuration
- Macro: `SIF_XA_CHECKSUM_EN`.
- **Defined:**
  - `rsp_checksum` port exists.
  - The running sum of `rsp_data` is taken over every successful READ, modulo 2^DATA_W.
  - It updates in the cycle `rsp_valid` rises.
  - Reset clears it to 0.
  - WRITEs and errors do not change it.
- **Undefined:** the port and adder are absent; all other behaviour is identical.

## Structure
- Shared package `sif_pkg`:
  - op enum (WRITE = 2'b10, READ = 2'b01, IDLE = 2'b00, ILLEGAL = 2'b11);
  - FSM state typedef;
  - default width constants.
- Sub-module `sif_xa_timer`:
  - clear/enable inputs and an `expired` output;
  - parameterized by TIMEOUT;
  - instantiated once.
- FSM and datapath stay in `sif_xa_initiator`.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-READ → strobes drop at the next edge; all outputs 0; `cmd_ready` = 1 one cycle after release.
- **Write:** op 10, addr 0x12, data 0xBEEF, ack 2 cycles after the strobe → `xa_wr_s` high 3 cycles with `xa_data_wr` = 0xBEEF; `rsp_data` = 0, `rsp_err` = 0.
- **Read:** op 01, addr 0x34, responder returns 0x1234 with ack in the first strobe cycle → `rsp_valid` 2 cycles after accept, `rsp_data` = 0x1234.
- **Timeout:** TIMEOUT = 4, no ack → `xa_rd_s` high exactly 4 cycles; `rsp_err` = 1, `rsp_data` = 0.
- **Illegal ops and stray ack:** ops 11 and 00 → no strobe; `rsp_err` = 1 at accept+1. Ack pulsed while IDLE has no effect.
- **Back-pressure and checksum:** `rsp_ready` held low 5 cycles → `cmd_ready` stays 0 and `rsp_data` stable. With `SIF_XA_CHECKSUM_EN`, reads returning 0xFFFF then 0x0002 → `rsp_checksum` = 0x0001.

Source files
------------

// File: rtl/sif_pkg.sv
// rtl/sif_pkg.sv - shared op/state types and default widths for the SIF XA bus
package sif_pkg;

    localparam int SIF_ADDR_W  = 8;
    localparam int SIF_DATA_W  = 16;
    localparam int SIF_TIMEOUT = 15;
    localparam int SIF_CNT_W   = 8;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_ILLEGAL = 2'b11
    } sif_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } sif_state_e;

endpackage

// File: rtl/sif_xa_initiator_if.sv
// rtl/sif_xa_initiator_if.sv - command, XA strobe bus and response signals (SIF_XA_CHECKSUM_EN adds rsp_checksum)
interface sif_xa_if import sif_pkg::*; #(
    parameter int ADDR_W = SIF_ADDR_W,
    parameter int DATA_W = SIF_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic              xa_ack;
    logic [DATA_W-1:0] xa_data_rd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
`ifdef SIF_XA_CHECKSUM_EN
    logic [DATA_W-1:0] rsp_checksum;
`endif

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, xa_ack, xa_data_rd, rsp_ready,
        output cmd_ready, xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, rsp_valid, rsp_data, rsp_err
`ifdef SIF_XA_CHECKSUM_EN
        , output rsp_checksum
`endif
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, xa_ack, xa_data_rd, rsp_ready,
        input  cmd_ready, xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, rsp_valid, rsp_data, rsp_err
`ifdef SIF_XA_CHECKSUM_EN
        , input rsp_checksum
`endif
    );

endinterface

// File: rtl/sif_xa_timer.sv
// rtl/sif_xa_timer.sv - saturating strobe-cycle counter flagging the last allowed cycle
module sif_xa_timer import sif_pkg::*; #(
    parameter int TIMEOUT = SIF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [SIF_CNT_W-1:0] LAST = SIF_CNT_W'(TIMEOUT - 1);

    logic [SIF_CNT_W-1:0] cnt_q;
    logic [SIF_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the strobe cycle that would be the TIMEOUT-th one.
    assign expired = enable && (cnt_q >= LAST);

endmodule

// File: rtl/sif_xa_initiator.sv
// rtl/sif_xa_initiator.sv - XA-bus initiator FSM and datapath; SIF_XA_CHECKSUM_EN enables rsp_checksum
module sif_xa_initiator import sif_pkg::*; #(
    parameter int ADDR_W  = SIF_ADDR_W,
    parameter int DATA_W  = SIF_DATA_W,
    parameter int TIMEOUT = SIF_TIMEOUT
) (
    input  logic     clk,
    input  logic     rst,
    sif_xa_if.master bus
);
    sif_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_s_q, wr_s_d;
    logic              rd_s_q, rd_s_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
`ifdef SIF_XA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    sif_xa_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign timer_enable = (state_q == ST_WRITE) || (state_q == ST_READ);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        wr_s_d      = wr_s_q;
        rd_s_d      = rd_s_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        timer_clear = 1'b0;
`ifdef SIF_XA_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    timer_clear = 1'b1;
                    if (bus.cmd_op == OP_WRITE) begin
                        state_d = ST_WRITE;
                        wr_s_d  = 1'b1;
                    end else if (bus.cmd_op == OP_READ) begin
                        state_d = ST_READ;
                        rd_s_d  = 1'b1;
                    end else begin
                        // Illegal op: answer at once without touching the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end
                end
            end
            ST_WRITE, ST_READ: begin
                if (bus.xa_ack) begin
                    state_d     = ST_RESP;
                    wr_s_d      = 1'b0;
                    rd_s_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = (state_q == ST_READ) ? bus.xa_data_rd : '0;
`ifdef SIF_XA_CHECKSUM_EN
                    if (state_q == ST_READ) begin
                        checksum_d = checksum_q + bus.xa_data_rd;
                    end
`endif
                end else if (timer_expired) begin
                    state_d     = ST_RESP;
                    wr_s_d      = 1'b0;
                    rd_s_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            default: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            wr_s_q      <= 1'b0;
            rd_s_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef SIF_XA_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wr_s_q      <= wr_s_d;
            rd_s_q      <= rd_s_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SIF_XA_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.xa_wr_s    = wr_s_q;
    assign bus.xa_rd_s    = rd_s_q;
    assign bus.xa_addr    = addr_q;
    assign bus.xa_data_wr = wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
`ifdef SIF_XA_CHECKSUM_EN
    assign bus.rsp_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_sif_xa_initiator.sv
// tb/tb_sif_xa_initiator.sv - scoreboard bench for sif_xa_initiator (honours SIF_XA_CHECKSUM_EN)
module tb_sif_xa_initiator;

    localparam int TMO = 4;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          delay;
        logic [15:0] rdval;
        int          acc_edge;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_stb;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int   n_cmp = 0;
    int   n_fail = 0;
    txn_t exp_q[$];
    bit   mon_en = 1'b0;
    bit   stray_ack = 1'b0;
    int   bp_hold = 0;
    logic [15:0] sum_model = 16'h0;

    sif_xa_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    sif_xa_initiator #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: what the response must be for a command given the responder's ack delay.
    function automatic txn_t make_txn(input logic [1:0] op, input logic [7:0] addr,
                                      input logic [15:0] wdata, input int delay, input logic [15:0] rdval);
        txn_t t;
        t.op = op; t.addr = addr; t.wdata = wdata; t.delay = delay; t.rdval = rdval; t.acc_edge = 0;
        if (op != 2'b10 && op != 2'b01) begin
            t.exp_err = 1'b1; t.exp_data = 16'h0; t.exp_stb = 0;
        end else if (delay < TMO) begin
            t.exp_err = 1'b0; t.exp_stb = delay + 1;
            t.exp_data = (op == 2'b01) ? rdval : 16'h0;
        end else begin
            t.exp_err = 1'b1; t.exp_data = 16'h0; t.exp_stb = TMO;
        end
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, "_strobes"}, 32'({bus.xa_wr_s, bus.xa_rd_s}), 32'd0);
        check({tag, "_xa_addr"}, 32'(bus.xa_addr), 32'd0);
        check({tag, "_xa_data_wr"}, 32'(bus.xa_data_wr), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
`ifdef SIF_XA_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(bus.rsp_checksum), 32'd0);
`endif
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wdata,
                         input int delay, input logic [15:0] rdval);
        txn_t t;
        int   waited = 0;
        bit   acc = 1'b0;
        t = make_txn(op, addr, wdata, delay, rdval);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        while (!acc && waited < 200) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                t.acc_edge = cyc + 1;
                exp_q.push_back(t);
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = 16'($urandom);
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: actual cmd_ready=0 for 200 cycles required accept");
        end
    endtask

    // Responder: acks in strobe cycle 'delay' (0 = first strobe cycle) of the head transaction.
    initial begin
        int rcnt = 0;
        bus.xa_ack = 1'b0;
        bus.xa_data_rd = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (bus.xa_wr_s || bus.xa_rd_s) begin
                if (exp_q.size() > 0 && exp_q[0].delay == rcnt) begin
                    bus.xa_ack = 1'b1;
                    bus.xa_data_rd = exp_q[0].rdval;
                end else begin
                    bus.xa_ack = stray_ack;
                    bus.xa_data_rd = 16'($urandom);
                end
                rcnt++;
            end else begin
                rcnt = 0;
                bus.xa_ack = stray_ack;
                bus.xa_data_rd = stray_ack ? 16'hA5A5 : 16'($urandom);
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bp_hold > 0) begin
                bus.rsp_ready = 1'b0;
                if (bus.rsp_valid) bp_hold--;
            end else begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        txn_t        t;
        int          stb_cnt = 0;
        int          rise_edge = 0;
        bit          prev_valid = 1'b0;
        logic [15:0] held_data = 16'h0;
        logic        held_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                stb_cnt = 0;
                prev_valid = 1'b0;
            end else begin
                check("strobe_exclusive", 32'(bus.xa_wr_s & bus.xa_rd_s), 32'd0);
                if (bus.xa_wr_s || bus.xa_rd_s) begin
                    stb_cnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL strobe_without_cmd: actual strobe high required none");
                    end else begin
                        check("xa_addr", 32'(bus.xa_addr), 32'(exp_q[0].addr));
                        check("strobe_kind", 32'({bus.xa_wr_s, bus.xa_rd_s}), 32'(exp_q[0].op));
                        if (exp_q[0].op == 2'b10)
                            check("xa_data_wr", 32'(bus.xa_data_wr), 32'(exp_q[0].wdata));
                    end
                end
                if (bus.rsp_valid) begin
                    check("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
                    if (!prev_valid) begin
                        rise_edge = cyc;
                        held_data = bus.rsp_data;
                        held_err  = bus.rsp_err;
                    end else begin
                        check("rsp_data_stable", 32'(bus.rsp_data), 32'(held_data));
                        check("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
                    end
                    if (bus.rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL rsp_without_cmd: actual rsp_valid=1 required no response");
                        end else begin
                            t = exp_q.pop_front();
                            check("rsp_data", 32'(bus.rsp_data), 32'(t.exp_data));
                            check("rsp_err", 32'(bus.rsp_err), 32'(t.exp_err));
                            check("strobe_cycles", 32'(stb_cnt), 32'(t.exp_stb));
                            check("latency", 32'(rise_edge - t.acc_edge + 1), 32'(t.exp_stb + 1));
                            if (!t.exp_err && t.op == 2'b01) sum_model = sum_model + t.exp_data;
`ifdef SIF_XA_CHECKSUM_EN
                            check("rsp_checksum", 32'(bus.rsp_checksum), 32'(sum_model));
`endif
                        end
                        stb_cnt = 0;
                    end
                    prev_valid = !bus.rsp_ready;
                end else begin
                    prev_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        int drain = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'h0;
        bus.cmd_wdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        // Reset in the middle of a read that is never acked.
        @(posedge clk); #1;
        issue(2'b01, 8'h56, 16'h0, 255, 16'h0);
        @(negedge clk);
        check("midread_strobe1", 32'(bus.xa_rd_s), 32'd1);
        @(negedge clk);
        check("midread_strobe2", 32'(bus.xa_rd_s), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("midread_reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        sum_model = 16'h0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_midread_reset", 32'(bus.cmd_ready), 32'd1);
        mon_en = 1'b1;

        // Stray ack while idle.
        @(posedge clk); #1;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("stray_no_strobe", 32'({bus.xa_wr_s, bus.xa_rd_s}), 32'd0);
            check("stray_ready", 32'(bus.cmd_ready), 32'd1);
        end
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(posedge clk); #1;

        issue(2'b01, 8'h40, 16'h0, 1, 16'hFFFF);
        issue(2'b01, 8'h41, 16'h0, 0, 16'h0002);
        issue(2'b10, 8'h12, 16'hBEEF, 2, 16'h0);
        issue(2'b01, 8'h34, 16'h0, 0, 16'h1234);
        issue(2'b01, 8'h78, 16'h0, 10, 16'h5555);
        issue(2'b10, 8'h79, 16'h1111, TMO - 1, 16'h0);
        issue(2'b11, 8'h9A, 16'h2222, 0, 16'h0);
        issue(2'b00, 8'h9B, 16'h3333, 0, 16'h0);
        issue(2'b01, 8'hC3, 16'h0, 3, 16'h4321);
        bp_hold = 5;

        for (int i = 0; i < 40; i++) begin
            int          r;
            logic [1:0]  op;
            r = int'($urandom_range(0, 9));
            op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 7) == 0) bp_hold = int'($urandom_range(1, 6));
            issue(op, 8'($urandom), 16'($urandom), int'($urandom_range(0, 6)), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        while (exp_q.size() > 0 && drain < 300) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: actual %0d responses outstanding required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
